pc_seq_ctrl: RTL and testbench
==============================

Name: pc_seq_ctrl

Overview:
- Fetch-side program-counter sequencer for the pipelined MIPS core.
- Owns the fetch PC and a decode-stage PC shadow, and accepts decoded redirect requests (JR, J/JAL, taken BEQ/BNE) from the decode stage.
- Computes next PC with fixed priority and squashes the wrong-path fetch after a redirect.
- Sits between the decode control logic and instruction memory; replaces the combinational JR next-PC selection.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 1, fetch-idle cycles after a redirect (legal range 1..3).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_ready  in  1  instruction memory can accept the address on pc this cycle
- stall  in  1  hazard stall from decode; freezes pc and decode shadow
- jr_req  in  1  decode instruction is JR (opcode 000, func 001000 already decoded)
- jump_req  in  1  decode instruction is J or JAL
- branch_taken  in  1  decode instruction is a branch whose condition is true
- jr_addr  in  32  ReadData1 register value for JR
- jump_index  in  26  instr[25:0]
- branch_offset  in  16  instr[15:0], signed word offset
- pc  out  32  current fetch address (registered)
- fetch_en  out  1  pc is valid for fetch this cycle
- flush  out  1  kill the IF/ID register contents this cycle
- dec_pc  out  32  PC of the instruction in decode
- link_addr  out  32  dec_pc + 4, for JAL writeback
- redirect  out  1  pulse: redirect taken this cycle

Behaviour:
- Reset values, applied asynchronously while reset=1:
  - pc=RESET_PC, dec_pc=RESET_PC
  - internal dec_valid=0, fetch_en=0, flush=0, redirect=0
  - state=BOOT
- States and transitions:
  - BOOT: fetch_en=0 for one cycle, then RUN.
  - RUN: fetch_en=1.
    - Fetch accept when fetch_en & imem_ready & ~stall: pc <= pc+4, dec_pc <= pc, dec_valid <= 1.
    - imem_ready=0 with ~stall: pc holds; dec_valid <= 0, which inserts a bubble.
  - FLUSH: fetch_en=0, flush=1, dec_valid=0. Counter runs FLUSH_CYCLES cycles, then RUN.
- Redirect condition, evaluated in RUN only: dec_valid & ~stall & (jr_req | jump_req | branch_taken).
  - Priority: jr_req > jump_req > branch_taken.
  - JR target = jr_addr.
  - J target = {link_addr[31:28], jump_index, 2'b00}.
  - Branch target = link_addr + {{14{branch_offset[15]}}, branch_offset, 2'b00}, mod 2^32 (wrap-around, no overflow flag).
- On redirect:
  - redirect is combinational, same cycle.
  - pc <= target at the edge; dec_valid <= 0; next state FLUSH.
  - The fetch accepted in the redirect cycle is discarded; no pc+4 increment.
- Timing and penalties:
  - Redirect penalty is FLUSH_CYCLES+1 cycles from redirect to the first fetch of the target.
  - link_addr = dec_pc + 4 (no delay slot), combinational.
- Redirect inputs are ignored when dec_valid=0, in BOOT, and in FLUSH.
- Stall together with a redirect request: stall wins. Nothing changes; the request must be held stable by decode until stall drops.
- Reset asserted mid-FLUSH or mid-redirect: immediate return to reset values; no residual flush.

Optional Feature:
- PC_ALIGN_CHECK_EN
- Defined:
  - A redirect whose target[1:0] != 2'b00 is not taken; the block enters HALT.
  - In HALT: fetch_en=0, flush=1, pc holds the faulting target, extra output addr_err=1. HALT is left only by reset.
- Undefined:
  - Target bits [1:0] are forced to 00; no HALT state and no addr_err port.

Decomposition:
- Shared package mips_pkg holds:
  - state enum (BOOT, RUN, FLUSH, HALT)
  - RESET_PC default constant
  - JR opcode/func constants (3'b000, 6'b001000)
- Sub-module pc_target_calc: purely combinational priority mux and target arithmetic (jr/jump/branch → target, valid). The FSM and registers stay in pc_seq_ctrl.

Test Plan:
- Reset release, imem_ready=1: pc=0 for BOOT cycle with fetch_en=0; then 0,4,8,C on successive cycles with fetch_en=1.
- JR at dec_pc=0x10 with jr_addr=0x200 and jump_req also set: redirect=1; pc=0x200 after the edge; flush=1 one cycle; fetch of 0x200 two cycles after redirect.
- BEQ taken at dec_pc=0x40, offset=16'hFFFC: target 0x34. Same at dec_pc=0xFFFFFFF0, offset=0x0008: target 0x00000014 (wrap-around).
- Stall held 3 cycles with jump_req pending, jump_index=0x100: pc and dec_pc frozen, redirect=0. On release, redirect to 0x400 in the first unstalled cycle.
- imem_ready low 2 cycles: pc held; dec_valid drops so a branch_taken asserted then is ignored.
- Reset pulsed during FLUSH: flush=0 and pc=RESET_PC immediately. With PC_ALIGN_CHECK_EN, JR to 0x202 → HALT, addr_err=1, pc=0x202.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch-side control path.
// Holds the PC sequencer state encoding, reset PC and JR decode constants.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } pc_state_e;

  localparam logic [31:0] MIPS_RESET_PC = 32'h0000_0000;

  localparam logic [2:0] JR_OPCODE = 3'b000;
  localparam logic [5:0] JR_FUNC   = 6'b001000;

  // Signed word offset to byte displacement.
  function automatic logic [31:0] br_disp(
    input logic [15:0] off
  );
    return {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target mux: jr_req > jump_req > branch_taken, plus arithmetic.
// Ports: request flags, jr_addr/jump_index/branch_offset/link_addr in; target, valid out.
module pc_target_calc
  import mips_pkg::*;
(
  input  logic        jr_req,
  input  logic        jump_req,
  input  logic        branch_taken,
  input  logic [31:0] jr_addr,
  input  logic [25:0] jump_index,
  input  logic [15:0] branch_offset,
  input  logic [31:0] link_addr,
  output logic [31:0] target,
  output logic        valid
);

  logic [31:0] j_tgt;
  logic [31:0] b_tgt;

  assign j_tgt = {link_addr[31:28], jump_index, 2'b00};
  // Wraps mod 2^32 by construction.
  assign b_tgt = link_addr + br_disp(branch_offset);

  always_comb begin
    target = 32'h0;
    valid  = 1'b0;
    priority case (1'b1)
      jr_req: begin
        target = jr_addr;
        valid  = 1'b1;
      end
      jump_req: begin
        target = j_tgt;
        valid  = 1'b1;
      end
      branch_taken: begin
        target = b_tgt;
        valid  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch PC sequencer: owns fetch pc and decode pc shadow, takes redirects.
// Ports: clock/reset, imem_ready, stall, redirect requests in;
// pc, fetch_en, flush, dec_pc, link_addr, redirect out.
// Option PC_ALIGN_CHECK_EN: misaligned target halts and raises addr_err.
module pc_seq_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = MIPS_RESET_PC,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        jr_req,
  input  logic        jump_req,
  input  logic        branch_taken,
  input  logic [31:0] jr_addr,
  input  logic [25:0] jump_index,
  input  logic [15:0] branch_offset,
  output logic [31:0] pc,
  output logic        fetch_en,
  output logic        flush,
  output logic [31:0] dec_pc,
  output logic [31:0] link_addr,
  output logic        redirect
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dec_pc_q, dec_pc_d;
  logic        dec_valid_q, dec_valid_d;
  logic [1:0]  cnt_q, cnt_d;

  logic [31:0] tgt_raw;
  logic [31:0] target;
  logic        tgt_valid;
  logic        req_ok;
  logic        fault;

  assign link_addr = dec_pc_q + 32'd4;

  pc_target_calc u_calc (
    .jr_req        (jr_req),
    .jump_req      (jump_req),
    .branch_taken  (branch_taken),
    .jr_addr       (jr_addr),
    .jump_index    (jump_index),
    .branch_offset (branch_offset),
    .link_addr     (link_addr),
    .target        (tgt_raw),
    .valid         (tgt_valid)
  );

  // Requests only count for a live decode slot in RUN; stall wins.
  assign req_ok = (state_q == ST_RUN) & dec_valid_q
                & ~stall & tgt_valid;

`ifdef PC_ALIGN_CHECK_EN
  assign target   = tgt_raw;
  assign fault    = req_ok & (|tgt_raw[1:0]);
  assign redirect = req_ok & ~(|tgt_raw[1:0]);
  assign addr_err = (state_q == ST_HALT);
`else
  assign target   = tgt_raw & ~32'h3;
  assign fault    = 1'b0;
  assign redirect = req_ok;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    dec_pc_d    = dec_pc_q;
    dec_valid_d = dec_valid_q;
    cnt_d       = cnt_q;
    fetch_en    = 1'b0;
    flush       = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        fetch_en = 1'b1;
        if (redirect) begin
          // Same-cycle fetch is dropped: no pc+4.
          pc_d        = target;
          dec_valid_d = 1'b0;
          cnt_d       = CNT_INIT;
          state_d     = ST_FLUSH;
        end else if (fault) begin
          pc_d        = tgt_raw;
          dec_valid_d = 1'b0;
          state_d     = ST_HALT;
        end else if (!stall) begin
          if (imem_ready) begin
            pc_d        = pc_q + 32'd4;
            dec_pc_d    = pc_q;
            dec_valid_d = 1'b1;
          end else begin
            dec_valid_d = 1'b0;
          end
        end
      end
      ST_FLUSH: begin
        flush       = 1'b1;
        dec_valid_d = 1'b0;
        if (cnt_q == 2'd0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_HALT: begin
        flush       = 1'b1;
        dec_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      dec_pc_q    <= RESET_PC;
      dec_valid_q <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dec_pc_q    <= dec_pc_d;
      dec_valid_q <= dec_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pc     = pc_q;
  assign dec_pc = dec_pc_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: boot, JR/J/branch redirects, stall,
// imem backpressure, reset during flush and target alignment.
module tb_pc_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_ready;
  logic        stall;
  logic        jr_req;
  logic        jump_req;
  logic        branch_taken;
  logic [31:0] jr_addr;
  logic [25:0] jump_index;
  logic [15:0] branch_offset;
  logic [31:0] pc;
  logic        fetch_en;
  logic        flush;
  logic [31:0] dec_pc;
  logic [31:0] link_addr;
  logic        redirect;
`ifdef PC_ALIGN_CHECK_EN
  logic        addr_err;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  pc_seq_ctrl #(
    .RESET_PC     (32'h0000_0000),
    .FLUSH_CYCLES (1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_ready    (imem_ready),
    .stall         (stall),
    .jr_req        (jr_req),
    .jump_req      (jump_req),
    .branch_taken  (branch_taken),
    .jr_addr       (jr_addr),
    .jump_index    (jump_index),
    .branch_offset (branch_offset),
    .pc            (pc),
    .fetch_en      (fetch_en),
    .flush         (flush),
    .dec_pc        (dec_pc),
    .link_addr     (link_addr),
    .redirect      (redirect)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .addr_err      (addr_err)
`endif
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic clr_req();
    jr_req       = 1'b0;
    jump_req     = 1'b0;
    branch_taken = 1'b0;
  endtask

  // Request already driven; walk redirect -> flush -> fetch -> decode.
  task automatic land(
    input string       tag,
    input logic [31:0] tgt
  );
    chk({tag, " redirect"}, {31'd0, redirect}, 32'd1);
    tick();
    clr_req();
    #1;
    chk({tag, " pc"}, pc, tgt);
    chk({tag, " flush"}, {31'd0, flush}, 32'd1);
    chk({tag, " fen0"}, {31'd0, fetch_en}, 32'd0);
    chk({tag, " rd0"}, {31'd0, redirect}, 32'd0);
    tick();
    chk({tag, " fen1"}, {31'd0, fetch_en}, 32'd1);
    chk({tag, " flush0"}, {31'd0, flush}, 32'd0);
    chk({tag, " pc2"}, pc, tgt);
    tick();
    chk({tag, " dec_pc"}, dec_pc, tgt);
    chk({tag, " pc3"}, pc, tgt + 32'd4);
  endtask

  initial begin
    reset         = 1'b1;
    imem_ready    = 1'b1;
    stall         = 1'b0;
    jr_addr       = '0;
    jump_index    = '0;
    branch_offset = '0;
    clr_req();
    #1;
    chk("rst pc", pc, 32'h0);
    chk("rst dec_pc", dec_pc, 32'h0);
    chk("rst fen", {31'd0, fetch_en}, 32'd0);
    chk("rst flush", {31'd0, flush}, 32'd0);
    chk("rst rd", {31'd0, redirect}, 32'd0);

    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("boot pc", pc, 32'h0);
    chk("boot fen", {31'd0, fetch_en}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("seq pc", pc, 32'(i * 4));
      chk("seq fen", {31'd0, fetch_en}, 32'd1);
    end
    tick();
    tick();
    chk("pre jr dec_pc", dec_pc, 32'h10);

    // JR beats J when both are asserted.
    jr_req     = 1'b1;
    jump_req   = 1'b1;
    jr_addr    = 32'h200;
    jump_index = 26'h3;
    #1;
    chk("jr link", link_addr, 32'h14);
    land("jr200", 32'h200);

    jr_req  = 1'b1;
    jr_addr = 32'h40;
    #1;
    land("jr40", 32'h40);

    branch_taken  = 1'b1;
    branch_offset = 16'hFFFC;
    #1;
    chk("beq link", link_addr, 32'h44);
    land("beq34", 32'h34);

    jr_req  = 1'b1;
    jr_addr = 32'hFFFF_FFF0;
    #1;
    land("jrhi", 32'hFFFF_FFF0);

    branch_taken  = 1'b1;
    branch_offset = 16'h0008;
    #1;
    land("beqwrap", 32'h14);

    // Stall with a pending jump: everything frozen.
    jump_req   = 1'b1;
    jump_index = 26'h100;
    stall      = 1'b1;
    #1;
    chk("stall rd", {31'd0, redirect}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall pc", pc, 32'h18);
      chk("stall dec_pc", dec_pc, 32'h14);
      chk("stall rd", {31'd0, redirect}, 32'd0);
    end
    stall = 1'b0;
    #1;
    land("j400", 32'h400);

    // imem backpressure: bubble in decode hides a branch.
    imem_ready = 1'b0;
    tick();
    chk("imem pc", pc, 32'h404);
    chk("imem dec_pc", dec_pc, 32'h400);
    branch_taken  = 1'b1;
    branch_offset = 16'h0004;
    #1;
    chk("bubble rd", {31'd0, redirect}, 32'd0);
    tick();
    chk("imem pc2", pc, 32'h404);
    chk("bubble rd2", {31'd0, redirect}, 32'd0);
    imem_ready = 1'b1;
    clr_req();
    tick();
    chk("resume pc", pc, 32'h408);
    chk("resume dec_pc", dec_pc, 32'h404);

    // Reset in the middle of FLUSH.
    jr_req  = 1'b1;
    jr_addr = 32'h300;
    tick();
    clr_req();
    #1;
    chk("mid flush", {31'd0, flush}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst2 flush", {31'd0, flush}, 32'd0);
    chk("rst2 pc", pc, 32'h0);
    chk("rst2 dec_pc", dec_pc, 32'h0);
    chk("rst2 fen", {31'd0, fetch_en}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("boot2 fen", {31'd0, fetch_en}, 32'd0);
    tick();
    chk("run2 pc", pc, 32'h0);
    tick();
    chk("run2 dec_pc", dec_pc, 32'h0);

    jr_req  = 1'b1;
    jr_addr = 32'h202;
    #1;
`ifdef PC_ALIGN_CHECK_EN
    chk("mis rd", {31'd0, redirect}, 32'd0);
    chk("mis err0", {31'd0, addr_err}, 32'd0);
    tick();
    clr_req();
    #1;
    chk("halt pc", pc, 32'h202);
    chk("halt err", {31'd0, addr_err}, 32'd1);
    chk("halt flush", {31'd0, flush}, 32'd1);
    chk("halt fen", {31'd0, fetch_en}, 32'd0);
    tick();
    chk("halt pc2", pc, 32'h202);
    chk("halt err2", {31'd0, addr_err}, 32'd1);
`else
    land("jralign", 32'h200);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
